// File: rtl/wb_multiport_bridge.sv
// wb_multiport_bridge: N native request/response ports arbitrated round-robin
// onto a single Wishbone classic master. Each port has a one-deep request
// latch; a bus timeout turns a missing ack into an error completion.
module wb_multiport_bridge #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                port_en_i,
  input  logic [NUM_PORTS-1:0]                port_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     port_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     port_data_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   port_strobe_i,
  output logic [NUM_PORTS-1:0]                port_valid_o,
  output logic [NUM_PORTS-1:0]                port_err_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     port_data_o,
  output logic                                wb_cyc_o,
  output logic                                wb_stb_o,
  output logic                                wb_we_o,
  output logic [ADDR_WIDTH-1:0]               wb_addr_o,
  output logic [DATA_WIDTH-1:0]               wb_data_o,
  output logic [DATA_WIDTH/8-1:0]             wb_sel_o,
  input  logic [DATA_WIDTH-1:0]               wb_data_i,
  input  logic                                wb_ack_i
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW        = GW + 1;
  localparam int TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [GW-1:0] LAST_PORT = GW'(NUM_PORTS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  // Reads with no byte enables fetch the whole word; writes use the strobe as given.
  function automatic logic [SEL_WIDTH-1:0] bus_sel(input logic we,
                                                   input logic [SEL_WIDTH-1:0] strobe);
    if (!we && (strobe == '0)) begin
      return '1;
    end else begin
      return strobe;
    end
  endfunction

  state_t                 state;
  state_t                 state_next;
  logic [NUM_PORTS-1:0]   pending;
  logic [NUM_PORTS-1:0]   lat_we;
  logic [ADDR_WIDTH-1:0]  lat_addr   [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  lat_data   [NUM_PORTS];
  logic [SEL_WIDTH-1:0]   lat_strobe [NUM_PORTS];

  logic [GW-1:0]          grant;
  logic [GW-1:0]          rr_ptr;
  logic [GW-1:0]          rr_next;
  logic [TW-1:0]          tmo_cnt;

  logic                   arb_found;
  logic [GW-1:0]          arb_idx;
  logic [CW-1:0]          arb_cand;
  logic                   arb_hit;
  logic                   arb_we;
  logic [ADDR_WIDTH-1:0]  arb_addr;
  logic [DATA_WIDTH-1:0]  arb_data;
  logic [SEL_WIDTH-1:0]   arb_strobe;

  logic                   ack_done;
  logic                   tmo_done;
  logic                   fin;

  assign fin     = ack_done | tmo_done;
  assign rr_next = (grant == LAST_PORT) ? '0 : grant + 1'b1;

  // Round-robin search: first pending port starting at rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    arb_hit   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      arb_cand = {1'b0, rr_ptr} + CW'(i);
      arb_cand = (arb_cand >= CW'(NUM_PORTS)) ? arb_cand - CW'(NUM_PORTS) : arb_cand;
      for (int p = 0; p < NUM_PORTS; p++) begin
        arb_hit   = !arb_found && (arb_cand == CW'(p)) && pending[p];
        arb_idx   = arb_hit ? GW'(p) : arb_idx;
        arb_found = arb_found | arb_hit;
      end
    end
  end

  // AND-OR mux selecting the latched request of the port about to be granted.
  always_comb begin
    arb_we     = 1'b0;
    arb_addr   = '0;
    arb_data   = '0;
    arb_strobe = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      arb_we     = arb_we | ((arb_idx == GW'(p)) & lat_we[p]);
      arb_addr   = arb_addr | ({ADDR_WIDTH{arb_idx == GW'(p)}} & lat_addr[p]);
      arb_data   = arb_data | ({DATA_WIDTH{arb_idx == GW'(p)}} & lat_data[p]);
      arb_strobe = arb_strobe | ({SEL_WIDTH{arb_idx == GW'(p)}} & lat_strobe[p]);
    end
  end

  // Next-state logic; an ack takes priority over a timeout in the same cycle.
  always_comb begin
    state_next = state;
    ack_done   = 1'b0;
    tmo_done   = 1'b0;
    case (state)
      IDLE: begin
        if (arb_found) begin
          state_next = BUS;
        end else begin
          state_next = IDLE;
        end
      end
      BUS: begin
        if (wb_ack_i) begin
          ack_done   = 1'b1;
          state_next = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST)) begin
          tmo_done   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = BUS;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant, round-robin pointer and bus timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant   <= '0;
      rr_ptr  <= '0;
      tmo_cnt <= '0;
    end else begin
      if ((state == IDLE) && arb_found) begin
        grant   <= arb_idx;
        tmo_cnt <= '0;
      end else if ((state == BUS) && !fin) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (fin) begin
        rr_ptr <= rr_next;
      end
    end
  end

  // Wishbone master outputs: loaded at grant and held stable for the whole BUS state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
      wb_sel_o  <= '0;
    end else if ((state == IDLE) && arb_found) begin
      wb_cyc_o  <= 1'b1;
      wb_stb_o  <= 1'b1;
      wb_we_o   <= arb_we;
      wb_addr_o <= arb_addr;
      wb_data_o <= arb_data;
      wb_sel_o  <= bus_sel(arb_we, arb_strobe);
    end else if (fin) begin
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
    end
  end

  // Per-port request latches; a new request is accepted in the completion cycle of the same port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      lat_we  <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        lat_addr[p]   <= '0;
        lat_data[p]   <= '0;
        lat_strobe[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_en_i[p] && (!pending[p] || (fin && (grant == GW'(p))))) begin
          pending[p]    <= 1'b1;
          lat_we[p]     <= port_we_i[p];
          lat_addr[p]   <= port_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
          lat_data[p]   <= port_data_i[p*DATA_WIDTH +: DATA_WIDTH];
          lat_strobe[p] <= port_strobe_i[p*SEL_WIDTH +: SEL_WIDTH];
        end else if (fin && (grant == GW'(p))) begin
          pending[p] <= 1'b0;
        end
      end
    end
  end

  // Completion pulses and read-data return toward the granted port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_valid_o <= '0;
      port_err_o   <= '0;
      port_data_o  <= '0;
    end else begin
      port_valid_o <= '0;
      port_err_o   <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (fin && (grant == GW'(p))) begin
          port_valid_o[p] <= 1'b1;
          port_err_o[p]   <= tmo_done;
          if (tmo_done) begin
            port_data_o[p*DATA_WIDTH +: DATA_WIDTH] <= '0;
          end else if (!wb_we_o) begin
            port_data_o[p*DATA_WIDTH +: DATA_WIDTH] <= wb_data_i;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_multiport_bridge.sv
// Self-checking bench for wb_multiport_bridge (2 ports, 8-cycle timeout):
// table-driven single transactions, hand-written multi-cycle sequences, and
// randomized traffic checked cycle by cycle against a behavioural model.
module tb_wb_multiport_bridge;

  localparam int NP  = 2;
  localparam int TMO = 8;

  logic          clk;
  logic          rst;
  logic [1:0]    en;
  logic [1:0]    we;
  logic [63:0]   addr;
  logic [63:0]   wdat;
  logic [7:0]    strb;
  logic [1:0]    valid;
  logic [1:0]    err;
  logic [63:0]   pdata;
  logic          cyc;
  logic          stb;
  logic          bwe;
  logic [31:0]   baddr;
  logic [31:0]   bdat;
  logic [3:0]    bsel;
  logic [31:0]   rdat;
  logic          ack;

  int tests;
  int fails;

  wb_multiport_bridge #(
    .NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .port_en_i(en), .port_we_i(we), .port_addr_i(addr), .port_data_i(wdat),
    .port_strobe_i(strb),
    .port_valid_o(valid), .port_err_o(err), .port_data_o(pdata),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(bwe), .wb_addr_o(baddr),
    .wb_data_o(bdat), .wb_sel_o(bsel), .wb_data_i(rdat), .wb_ack_i(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: request slots, round-robin start, current bus owner.
  logic [1:0]  m_pend;
  logic        m_rwe   [NP];
  logic [31:0] m_raddr [NP];
  logic [31:0] m_rdat  [NP];
  logic [3:0]  m_rstb  [NP];
  logic [31:0] m_pdata [NP];
  int          m_bus;
  int          m_cnt;
  int          m_rr;
  logic [1:0]  e_valid;
  logic [1:0]  e_err;

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    int          wait_n;
    logic [31:0] rdata;
    logic [3:0]  exp_sel;
    logic [31:0] exp_pdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_cyc_cnt;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_sel(input logic w, input logic [3:0] s);
    return (!w && (s == 4'h0)) ? 4'hF : s;
  endfunction

  task automatic model_reset();
    m_pend = 2'b00;
    m_bus  = -1;
    m_cnt  = 0;
    m_rr   = 0;
    for (int p = 0; p < NP; p++) begin
      m_rwe[p] = 1'b0; m_raddr[p] = 32'h0; m_rdat[p] = 32'h0;
      m_rstb[p] = 4'h0; m_pdata[p] = 32'h0;
    end
  endtask

  task automatic set_req(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    we[p]          = w;
    addr[p*32 +: 32] = a;
    wdat[p*32 +: 32] = d;
    strb[p*4 +: 4]   = s;
  endtask

  // One clock: apply en/ack/read data, advance the model, check every output.
  task automatic cycle(input logic [1:0] en_in, input logic ack_in, input logic [31:0] rd_in);
    logic [1:0] old_pend;
    int         fin_port;
    logic       done;
    logic       found;
    int         k;
    en       = en_in;
    ack      = ack_in;
    rdat     = rd_in;
    old_pend = m_pend;
    e_valid  = 2'b00;
    e_err    = 2'b00;
    fin_port = -1;
    if (m_bus >= 0) begin
      done = ack_in || (m_cnt == TMO - 1);
      if (done) begin
        fin_port         = m_bus;
        e_valid[m_bus]   = 1'b1;
        e_err[m_bus]     = !ack_in;
        if (!ack_in) m_pdata[m_bus] = 32'h0;
        else if (!m_rwe[m_bus]) m_pdata[m_bus] = rd_in;
        m_pend[m_bus]    = 1'b0;
        m_rr             = (m_bus + 1) % NP;
        m_bus            = -1;
      end else begin
        m_cnt++;
      end
    end else begin
      found = 1'b0;
      for (int i = 0; i < NP; i++) begin
        k = (m_rr + i) % NP;
        if (!found && old_pend[k]) begin
          found = 1'b1;
          m_bus = k;
          m_cnt = 0;
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (en_in[p] && (!old_pend[p] || (p == fin_port))) begin
        m_pend[p]  = 1'b1;
        m_rwe[p]   = we[p];
        m_raddr[p] = addr[p*32 +: 32];
        m_rdat[p]  = wdat[p*32 +: 32];
        m_rstb[p]  = strb[p*4 +: 4];
      end
    end
    @(posedge clk);
    #1;
    chk("cyc", cyc, m_bus >= 0);
    chk("stb", stb, m_bus >= 0);
    chk("valid", valid, e_valid);
    chk("err", err, e_err);
    chk("pdata", pdata, {m_pdata[1], m_pdata[0]});
    if (m_bus >= 0) begin
      chk("bus_we", bwe, m_rwe[m_bus]);
      chk("bus_addr", baddr, m_raddr[m_bus]);
      chk("bus_wdata", bdat, m_rdat[m_bus]);
      chk("bus_sel", bsel, exp_sel(m_rwe[m_bus], m_rstb[m_bus]));
    end
    en  = 2'b00;
    ack = 1'b0;
  endtask

  // Both ports request together; slave acks after two wait cycles.
  task automatic contend(input int exp_first, input string nm);
    int   first, second, gap, busc, nval, port;
    logic prev_cyc, a;
    first = -1; second = -1; gap = 0; busc = 0; nval = 0; prev_cyc = 1'b0;
    set_req(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
    set_req(1, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
    cycle(2'b11, 1'b0, 32'h0);
    for (int c = 0; c < 40 && nval < 2; c++) begin
      a = 1'b0;
      if (cyc) begin
        if (!prev_cyc) begin
          port = (baddr == 32'h0000_1000) ? 0 : 1;
          if (first < 0) first = port; else second = port;
          busc = 0;
        end
        a = (busc == 2);
        busc++;
      end else if (first >= 0 && second < 0) begin
        gap++;
      end
      prev_cyc = cyc;
      cycle(2'b00, a, 32'h0000_0100 + c);
      nval += int'(valid[0]) + int'(valid[1]);
    end
    chk({nm, "_first"}, first, exp_first);
    chk({nm, "_second"}, second, 1 - exp_first);
    chk({nm, "_gap"}, gap, 1);
    chk({nm, "_nvalid"}, nval, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   c, busc, lat, nval, rw;
    logic got, a, prev;
    vec_t v;

    //          port we    addr          wdata         strb   wait rdata         sel    pdata         err  lat cyc
    tbl[0] = '{0, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 0,  32'h0000_0013, 4'hF, 32'h0000_0013, 1'b0, 3,  1};
    tbl[1] = '{1, 1'b1, 32'h8000_0004, 32'hAABB_CCDD, 4'h4, 1,  32'hDEAD_BEEF, 4'h4, 32'h0000_0000, 1'b0, 4,  2};
    tbl[2] = '{1, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'h3, 2,  32'h1234_5678, 4'h3, 32'h1234_5678, 1'b0, 5,  3};
    tbl[3] = '{1, 1'b1, 32'h0000_0104, 32'h5555_AAAA, 4'hF, 0,  32'hFFFF_FFFF, 4'hF, 32'h1234_5678, 1'b0, 3,  1};
    tbl[4] = '{0, 1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 20, 32'h0000_0077, 4'hF, 32'h0000_0000, 1'b1, 10, 8};
    tbl[5] = '{0, 1'b0, 32'h0000_0024, 32'h0000_0000, 4'h8, 7,  32'hCAFE_F00D, 4'h8, 32'hCAFE_F00D, 1'b0, 10, 8};
    tbl[6] = '{1, 1'b1, 32'h0000_0200, 32'h0BAD_F00D, 4'h1, 30, 32'h0000_0000, 4'h1, 32'h0000_0000, 1'b1, 10, 8};

    tests = 0; fails = 0;
    rst = 1'b1; en = 2'b00; we = 2'b00; addr = 64'h0; wdat = 64'h0; strb = 8'h0;
    rdat = 32'h0; ack = 1'b0;
    model_reset();
    #1;
    chk("rst_cyc", cyc, 1'b0);
    chk("rst_stb", stb, 1'b0);
    chk("rst_valid", valid, 2'b00);
    chk("rst_err", err, 2'b00);
    chk("rst_pdata", pdata, 64'h0);
    chk("rst_bus", {bwe, baddr, bdat, bsel}, 69'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven single transactions.
    for (int i = 0; i < 7; i++) begin
      v = tbl[i];
      set_req(v.port, v.we, v.addr, v.wdata, v.strobe);
      cycle(2'b01 << v.port, 1'b0, 32'h0);
      c = 1; busc = 0; got = 1'b0; lat = 0;
      while (!got && c < 40) begin
        a = cyc && (busc == v.wait_n);
        if (cyc) begin
          chk("tbl_sel", bsel, v.exp_sel);
          chk("tbl_addr", baddr, v.addr);
          chk("tbl_we", bwe, v.we);
          if (v.we) chk("tbl_wdata", bdat, v.wdata);
          busc++;
        end
        cycle(2'b00, a, v.rdata);
        c++;
        if (valid[v.port]) begin
          got = 1'b1;
          lat = c;
        end
      end
      chk("tbl_done", got, 1'b1);
      chk("tbl_latency", lat, v.exp_lat);
      chk("tbl_cyc_cycles", busc, v.exp_cyc_cnt);
      chk("tbl_err", err[v.port], v.exp_err);
      chk("tbl_pdata", pdata[v.port*32 +: 32], v.exp_pdata);
      cycle(2'b00, 1'b0, 32'h0);
    end

    // Contention: port 0 first; after a lone port-0 transaction, port 1 first.
    contend(0, "contend_a");
    set_req(0, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
    cycle(2'b01, 1'b0, 32'h0);
    cycle(2'b00, 1'b0, 32'h0);
    cycle(2'b00, 1'b1, 32'h0000_4444);
    chk("solo_valid", valid, 2'b01);
    contend(1, "contend_b");

    // Back-to-back: new port-0 request in its own ack cycle.
    set_req(0, 1'b0, 32'h0000_0030, 32'h0, 4'h0);
    cycle(2'b01, 1'b0, 32'h0);
    cycle(2'b00, 1'b0, 32'h0);
    chk("b2b_cyc1", cyc, 1'b1);
    set_req(0, 1'b0, 32'h0000_0034, 32'h0, 4'h0);
    cycle(2'b01, 1'b1, 32'hAAAA_0001);
    chk("b2b_valid1", valid[0], 1'b1);
    chk("b2b_data1", pdata[31:0], 32'hAAAA_0001);
    chk("b2b_idle", cyc, 1'b0);
    cycle(2'b00, 1'b0, 32'h0);
    chk("b2b_cyc2", cyc, 1'b1);
    chk("b2b_addr2", baddr, 32'h0000_0034);
    cycle(2'b00, 1'b1, 32'hAAAA_0002);
    chk("b2b_valid2", valid[0], 1'b1);
    chk("b2b_data2", pdata[31:0], 32'hAAAA_0002);
    cycle(2'b00, 1'b0, 32'h0);

    // Reset mid-BUS after port 0 was last granted; port 0 must win again afterwards.
    set_req(0, 1'b0, 32'h0000_0050, 32'h0, 4'hF);
    cycle(2'b01, 1'b0, 32'h0);
    cycle(2'b00, 1'b0, 32'h0);
    chk("mid_cyc", cyc, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_cyc", cyc, 1'b0);
    chk("mid_rst_stb", stb, 1'b0);
    chk("mid_rst_valid", valid, 2'b00);
    chk("mid_rst_pdata", pdata, 64'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_novalid", valid, 2'b00);
    rst = 1'b0;
    model_reset();
    contend(0, "post_rst");

    // Randomized traffic against the model.
    busc = 0; rw = 0; prev = 1'b0;
    for (int i = 0; i < 500; i++) begin
      for (int p = 0; p < NP; p++) begin
        set_req(p, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      end
      a = 1'b0;
      if (cyc) begin
        if (!prev) begin
          busc = 0;
          rw   = $urandom_range(0, 9);
        end
        a = (busc == rw);
        busc++;
      end else begin
        a = ($urandom_range(0, 7) == 0);
      end
      prev = cyc;
      cycle({1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)}, a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
